// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: FSM state encoding,
// wait-counter width, PROM region default and the byte-enable decode.
package mem_arbiter_pkg;

  // Wait counter width; covers WAIT values 0..15.
  localparam int unsigned CNT_W = 4;

  // Default value of adr[23:14] that selects the on-chip PROM.
  localparam logic [9:0] ROM_HI_DEF = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_ACC  = 2'd1,
    ST_CPU_DONE = 2'd2,
    ST_VID_ACC  = 2'd3
  } state_e;

  // Word accesses enable all lanes; byte accesses enable the lane
  // addressed by the two low address bits.
  function automatic logic [3:0] be_decode(input logic ben, input logic [1:0] adr_lo);
    logic [3:0] be;
    if (!ben) be = 4'b1111;
    else      be = 4'b0001 << adr_lo;
    return be;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times one memory access. It is loaded with
// the wait count at the grant, counts down while enabled and parks at 0.
module mem_wait_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: load wins over decrement; never wraps below zero.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: sequences CPU fetch/load/store cycles and video
// refresh reads onto one word-wide memory port, stalls the CPU with
// memwait and returns read data to the CPU and the display controller.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT   = 1,
  parameter logic [9:0]  ROM_HI = ROM_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // CPU side
  input  logic [23:0] cpu_adr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_ben,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        memwait,
  // Video side
  input  logic        vid_req,
  input  logic [21:0] vid_adr,
  output logic        vid_ack,
  output logic [31:0] vid_data,
  // Memory side
  output logic [21:0] mem_adr,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_L = CNT_W'(WAIT);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_last_vid;
  logic [31:0]      r_rdata;
  logic             r_vid_ack;
  logic             r_mem_ce;
  logic             r_mem_we;
  logic [3:0]       r_mem_be;
  logic [21:0]      r_mem_adr;
  logic [31:0]      r_mem_wdata;

  logic             w_cpu_need;
  logic             w_vid_need;
  logic             w_grant_cpu;
  logic             w_grant_vid;
  logic             w_acc_end;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt;

  // Any load or store needs memory; a fetch needs it unless it is served
  // by the on-chip PROM. Stores into the PROM region still go to memory.
  assign w_cpu_need = cpu_rd | cpu_wr | (cpu_adr[23:14] != ROM_HI);

  // In the ack cycle vid_req is still high for the request just served;
  // masking it keeps that request from being granted a second time.
  assign w_vid_need = vid_req & ~r_vid_ack;

  assign w_cnt_dec = (r_state == ST_CPU_ACC) || (r_state == ST_VID_ACC);

  mem_wait_counter u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_grant_cpu | w_grant_vid),
    .i_load_val (WAIT_L),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Next-state and grant decode; CPU_DONE arbitrates like IDLE but only
  // video may win, so the CPU re-arbitrates from the following cycle.
  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_grant_cpu  = 1'b0;
    w_grant_vid  = 1'b0;
    w_acc_end    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_need && (!w_vid_need || r_last_vid)) begin
          w_grant_cpu  = 1'b1;
          w_state_next = ST_CPU_ACC;
        end else if (w_vid_need) begin
          w_grant_vid  = 1'b1;
          w_state_next = ST_VID_ACC;
        end
      end
      ST_CPU_DONE: begin
        if (w_vid_need) begin
          w_grant_vid  = 1'b1;
          w_state_next = ST_VID_ACC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CPU_ACC: begin
        if (w_cnt_zero) begin
          w_acc_end    = 1'b1;
          w_state_next = ST_CPU_DONE;
        end
      end
      ST_VID_ACC: begin
        if (w_cnt_zero) begin
          w_acc_end    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Memory port registers: loaded at the grant, held for the access,
  // released at its last cycle; read data captured in that last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_last_vid  <= 1'b0;
    end else if (w_grant_cpu) begin
      r_mem_ce    <= 1'b1;
      r_mem_we    <= cpu_wr;
      r_mem_be    <= be_decode(cpu_ben, cpu_adr[1:0]);
      r_mem_adr   <= cpu_adr[23:2];
      r_mem_wdata <= cpu_wdata;
      r_last_vid  <= 1'b0;
    end else if (w_grant_vid) begin
      r_mem_ce    <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b1111;
      r_mem_adr   <= vid_adr;
      r_last_vid  <= 1'b1;
    end else if (w_acc_end) begin
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_rdata     <= mem_rdata;
    end
  end

  // One-cycle video acknowledge following the last cycle of a video access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vid_ack <= 1'b0;
    else     r_vid_ack <= w_acc_end && (r_state == ST_VID_ACC);
  end

  // Outside an access the wait counter must always be parked at zero.
  a_cnt_idle_zero : assert property (@(posedge clk) disable iff (rst)
    !w_cnt_dec |-> (w_cnt == '0));

  assign memwait   = w_cpu_need & (r_state != ST_CPU_DONE);
  assign cpu_rdata = r_rdata;
  assign vid_ack   = r_vid_ack;
  assign vid_data  = r_rdata;
  assign mem_adr   = r_mem_adr;
  assign mem_ce    = r_mem_ce;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Three instances share the stimulus:
// index 0 has WAIT=1, index 1 WAIT=0, index 2 WAIT=3.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cpu_adr;
  logic        cpu_rd, cpu_wr, cpu_ben;
  logic [31:0] cpu_wdata;
  logic        vid_req;
  logic [21:0] vid_adr;
  logic [31:0] mem_rdata;

  logic [31:0] cpu_rdata [3];
  logic        memwait   [3];
  logic        vid_ack   [3];
  logic [31:0] vid_data  [3];
  logic [21:0] mem_adr   [3];
  logic        mem_ce    [3];
  logic        mem_we    [3];
  logic [3:0]  mem_be    [3];
  logic [31:0] mem_wdata [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.WAIT((g == 0) ? 1 : (g == 1) ? 0 : 3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_adr   (cpu_adr),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_ben   (cpu_ben),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata[g]),
      .memwait   (memwait[g]),
      .vid_req   (vid_req),
      .vid_adr   (vid_adr),
      .vid_ack   (vid_ack[g]),
      .vid_data  (vid_data[g]),
      .mem_adr   (mem_adr[g]),
      .mem_ce    (mem_ce[g]),
      .mem_we    (mem_we[g]),
      .mem_be    (mem_be[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_adr   = 24'hFFC000;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_ben   = 1'b0;
    cpu_wdata = '0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    vid_req = 1'b0;
    vid_adr = '0;
    cpu_idle();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Expected per-cycle behaviour of the WAIT=0 instance under contention.
  logic   exp_ce  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic   exp_ack [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic   exp_mw  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  state_e exp_st  [9] = '{ST_IDLE, ST_VID_ACC, ST_IDLE, ST_CPU_ACC, ST_CPU_DONE,
                          ST_VID_ACC, ST_IDLE, ST_CPU_ACC, ST_CPU_DONE};

  initial begin
    logic ce_seen, ack_seen, mw_seen;
    logic [21:0] exp_adr;

    mem_rdata = 32'h0;
    rst       = 1'b1;
    vid_req   = 1'b0;
    vid_adr   = '0;
    cpu_idle();
    #2;
    // Reset values
    check("rst_ce",    32'(mem_ce[0]),  32'h0);
    check("rst_we",    32'(mem_we[0]),  32'h0);
    check("rst_be",    32'(mem_be[0]),  32'h0);
    check("rst_adr",   32'(mem_adr[0]), 32'h0);
    check("rst_ack",   32'(vid_ack[0]), 32'h0);
    check("rst_rdata", cpu_rdata[0],    32'h0);
    check("rst_state", 32'(g_dut[0].u_dut.r_state), 32'(ST_IDLE));
    do_reset();

    // 1: uncontended fetch, WAIT=1
    cpu_adr   = 24'h000100;
    mem_rdata = 32'hDEADBEEF;
    #1;
    check("t1_mw_c0", 32'(memwait[0]), 32'h1);
    check("t1_ce_c0", 32'(mem_ce[0]),  32'h0);
    tick();
    check("t1_ce_c1",  32'(mem_ce[0]),  32'h1);
    check("t1_adr_c1", 32'(mem_adr[0]), 32'h000040);
    check("t1_we_c1",  32'(mem_we[0]),  32'h0);
    check("t1_be_c1",  32'(mem_be[0]),  32'hF);
    check("t1_mw_c1",  32'(memwait[0]), 32'h1);
    tick();
    check("t1_ce_c2", 32'(mem_ce[0]),  32'h1);
    check("t1_mw_c2", 32'(memwait[0]), 32'h1);
    tick();
    check("t1_ce_c3",    32'(mem_ce[0]),  32'h0);
    check("t1_mw_c3",    32'(memwait[0]), 32'h0);
    check("t1_rdata_c3", cpu_rdata[0],    32'hDEADBEEF);

    // 3: PROM-region fetch never stalls and never touches memory
    cpu_adr = 24'hFFE000;
    ce_seen = 1'b0;
    mw_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      ce_seen |= mem_ce[0] & (i > 0);
      mw_seen |= memwait[0];
      tick();
    end
    check("t3_mw_never", 32'(mw_seen), 32'h0);
    check("t3_ce_never", 32'(ce_seen), 32'h0);

    // 2: byte store to lane 3
    cpu_adr   = 24'h000203;
    cpu_wr    = 1'b1;
    cpu_ben   = 1'b1;
    cpu_wdata = 32'h55000000;
    tick();
    check("t2_ce",    32'(mem_ce[0]),  32'h1);
    check("t2_we",    32'(mem_we[0]),  32'h1);
    check("t2_be",    32'(mem_be[0]),  32'h8);
    check("t2_adr",   32'(mem_adr[0]), 32'h000080);
    check("t2_wdata", mem_wdata[0],    32'h55000000);
    tick();
    tick();
    check("t2_mw_done", 32'(memwait[0]), 32'h0);
    check("t2_ce_done", 32'(mem_ce[0]),  32'h0);
    cpu_idle();
    tick();

    // 6: video request withdrawn during a CPU access is never served
    cpu_adr   = 24'h000400;
    cpu_rd    = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    vid_adr = 22'h3ABCD;
    vid_req = 1'b1;
    check("t6_adr_cpu", 32'(mem_adr[0]), 32'h000100);
    tick();
    vid_req = 1'b0;
    tick();
    check("t6_state_done", 32'(g_dut[0].u_dut.r_state), 32'(ST_CPU_DONE));
    check("t6_rdata",      cpu_rdata[0], 32'h12345678);
    cpu_idle();
    ce_seen  = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ce_seen  |= mem_ce[0];
      ack_seen |= vid_ack[0];
    end
    check("t6_no_ce",  32'(ce_seen),  32'h0);
    check("t6_no_ack", 32'(ack_seen), 32'h0);
    check("t6_adr",    32'(mem_adr[0]), 32'h000100);

    // 4: continuous contention, WAIT=0 -> video, CPU, video, CPU
    do_reset();
    vid_adr   = 22'h2AAAA;
    vid_req   = 1'b1;
    cpu_adr   = 24'h000800;
    cpu_rd    = 1'b1;
    mem_rdata = 32'hCAFE0001;
    #1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      check($sformatf("t4_ce_%0d", k),  32'(mem_ce[1]),  32'(exp_ce[k]));
      check($sformatf("t4_ack_%0d", k), 32'(vid_ack[1]), 32'(exp_ack[k]));
      check($sformatf("t4_mw_%0d", k),  32'(memwait[1]), 32'(exp_mw[k]));
      check($sformatf("t4_st_%0d", k),  32'(g_dut[1].u_dut.r_state), 32'(exp_st[k]));
      if (exp_ce[k]) begin
        exp_adr = (k == 1 || k == 5) ? 22'h2AAAA : 22'h000200;
        check($sformatf("t4_adr_%0d", k), 32'(mem_adr[1]), 32'(exp_adr));
      end
      if (exp_ack[k])
        check($sformatf("t4_vdata_%0d", k), vid_data[1], 32'hCAFE0001);
    end
    check("t4_rdata_done", cpu_rdata[1], 32'hCAFE0001);
    vid_req = 1'b0;
    cpu_idle();

    // 5: reset in the second cycle of a WAIT=3 video access
    do_reset();
    vid_adr   = 22'h15555;
    vid_req   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    tick();
    check("t5_ce_a1", 32'(mem_ce[2]), 32'h1);
    tick();
    check("t5_ce_a2", 32'(mem_ce[2]), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("t5_ce_async", 32'(mem_ce[2]),  32'h0);
    check("t5_ack_rst",  32'(vid_ack[2]), 32'h0);
    check("t5_st_rst",   32'(g_dut[2].u_dut.r_state), 32'(ST_IDLE));
    tick();
    check("t5_ack_hold", 32'(vid_ack[2]), 32'h0);
    rst = 1'b0;
    tick();
    check("t5_ce_regrant",  32'(mem_ce[2]),  32'h1);
    check("t5_adr_regrant", 32'(mem_adr[2]), 32'h15555);
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ack_seen |= vid_ack[2];
    end
    check("t5_ack_early", 32'(ack_seen), 32'h0);
    tick();
    check("t5_ack",   32'(vid_ack[2]),  32'h1);
    check("t5_vdata", vid_data[2],      32'h0BADF00D);
    check("t5_ce_end", 32'(mem_ce[2]),  32'h0);
    vid_req = 1'b0;
    tick();
    check("t5_ack_once", 32'(vid_ack[2]), 32'h0);
    check("t5_ce_idle",  32'(mem_ce[2]),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences every RISC5cpu memory cycle (instruction fetch, load, store) onto one shared word-wide main-memory port.
- Shares that port with the video refresh reader.
- Generates the CPU's memwait stall and returns read data on inbus/codebus.
- Sits between RISC5cpu, the display controller and the external SRAM pins module.

Parameters:
WAIT, 1, extra memory wait cycles per access; an access occupies WAIT+1 cycles (WAIT 0..15).
ROM_HI, 10'h3FF, value of CPU adr[23:14] that selects the on-chip PROM; no memory access is made for fetches in this region.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cpu_adr  in  24  CPU byte address (adr)
cpu_rd  in  1  CPU load strobe
cpu_wr  in  1  CPU store strobe
cpu_ben  in  1  CPU byte access
cpu_wdata  in  32  CPU store data (outbus), bytes already lane-steered
cpu_rdata  out  32  to CPU inbus and codebus
memwait  out  1  CPU stall; high = CPU frozen
vid_req  in  1  video word request, level, held until vid_ack
vid_adr  in  22  video word address
vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle
vid_data  out  32  video read data
mem_adr  out  22  memory word address
mem_ce  out  1  memory access active
mem_we  out  1  write access
mem_be  out  4  byte enables
mem_wdata  out  32  write data
mem_rdata  in  32  memory read data, valid in the last access cycle

Behaviour:
- Reset: clk and rst as named; rst is asynchronous, active-high.
- Values while rst is high: state IDLE, cnt 0, last_vid 0, rdata register 0, vid_ack 0, mem_ce 0, mem_we 0, mem_be 0, mem_adr 0.
- cpu_need = cpu_rd | cpu_wr | (cpu_adr[23:14] != ROM_HI).
  - With rd and wr both low, the CPU is fetching at cpu_adr.
- States: IDLE, CPU_ACC, CPU_DONE, VID_ACC.
- IDLE, selection:
  - Only one requester present: that one is granted.
  - Both present: video is granted unless last_vid=1, in which case the CPU is granted.
  - last_vid is set on a video grant and cleared on a CPU grant.
- Grant action: go to CPU_ACC or VID_ACC and load cnt=WAIT.
  - mem_* outputs are registered at the grant and held constant for the whole access.
- CPU access mapping:
  - mem_adr = cpu_adr[23:2].
  - mem_we = cpu_wr.
  - mem_be = 4'b1111 when ~cpu_ben; otherwise one-hot 1<<cpu_adr[1:0].
  - mem_wdata = cpu_wdata.
- Video access mapping: mem_adr = vid_adr, mem_we=0, mem_be=4'b1111.
- CPU_ACC / VID_ACC:
  - cnt decrements each cycle.
  - At cnt==0, rdata captures mem_rdata, mem_ce drops next cycle, and the FSM goes to CPU_DONE (CPU) or IDLE (video).
  - On the video path, vid_ack pulses in the cycle after cnt==0 with vid_data = rdata.
- CPU_DONE:
  - Lasts exactly one cycle; cpu_rdata = rdata.
  - The memory-side decision is the same as IDLE with cpu_need forced to 0; the CPU re-arbitrates from the next cycle.
- memwait (combinational) = cpu_need & (state != CPU_DONE).
  - Consequence: a PROM-region fetch with no rd/wr never stalls.
- Latency: a CPU access with no contention takes WAIT+2 cycles from first demand to memwait low. Worst case adds one full video access, WAIT+1 cycles.
- CPU stability: the CPU holds adr, rd, wr, ben and outbus stable while memwait is high. The arbiter samples them only at the grant.
- Store to the PROM region: still performed; ROM_HI gates fetches only.
- cpu_rdata always drives rdata; its value is meaningful only in CPU_DONE.
- vid_req dropped before its grant: the request is ignored, with no ack.
- Once granted, an access always completes and cannot be aborted.
- rst asserted mid-access: immediate return to IDLE; mem_ce drops asynchronously; no vid_ack is issued; the pending CPU access is discarded (the CPU restarts at StartAdr).

Decomposition:
- Shared package: state encoding (2 bits), the ROM_HI default, and the byte-enable decode function (ben, adr[1:0] -> be[3:0]).
- One natural sub-module, mem_wait_counter: a loadable down-counter providing cnt and its zero flag.
- The FSM, arbitration and muxes stay in mem_arbiter.

Test Plan:
1. WAIT=1; CPU fetch at adr 24'h000100 with mem_rdata=32'hDEADBEEF -> mem_ce for 2 cycles with mem_adr=22'h000040; memwait low in cycle 3; cpu_rdata=32'hDEADBEEF.
2. Byte store: cpu_wr=1, cpu_ben=1, adr 24'h000203, wdata 32'h55000000 -> mem_we=1, mem_be=4'b1000, mem_adr=22'h000080.
3. PROM fetch at adr 24'hFFE000 with rd=wr=0 -> memwait stays 0 and mem_ce stays 0.
4. CPU and video requesting continuously, WAIT=0 -> grant order video, CPU, video, CPU; vid_ack pulses once per video access; every CPU access ends in CPU_DONE.
5. rst pulsed during the second cycle of a WAIT=3 video access -> mem_ce=0 at once; no vid_ack; state IDLE; the first access after release is granted normally.
6. vid_req raised then dropped while the CPU access is in progress -> no video access and no vid_ack.
